kf_microseq: RTL and testbench
==============================

// Module: kf_microseq
// PURPOSE
//   Parametrised microcode sequencer for the Kalman-filter datapath: PC-addressed control store,
//   flow ops (jump, call/return, counted loop), wait-for-continue with timeout, abort, error codes.
//   Drives the full control word to the AU/datapath. Store is programmable only while idle.
// PARAMETERS
//   PC_W     8   PC/address width; store depth = 2**PC_W words
//   IW       16  instruction width; must be >= PC_W+3 (elaboration error otherwise)
//   STACK_D  4   return-stack depth (entries), >= 1
//   CNT_W    8   loop-counter width (<= PC_W; loaded from target field LSBs)
//   TMO_CYC  1024 WAIT timeout in cycles; 0 disables timeout
// PORTS
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      1-cycle pulse, begin run at start_addr (honoured only when idle)
//   start_addr  in   PC_W   entry address sampled with start
//   abort       in   1      stop run immediately
//   continue_i  in   1      release for WAIT (e.g. reciprocal done)
//   prog_we     in   1      control-store write enable (ignored while running)
//   prog_addr   in   PC_W   write address
//   prog_data   in   IW     write data
//   prog_err    out  1      1-cycle pulse: prog_we asserted while running
//   ctl_word    out  IW     current instruction mem[pc] (asynchronous read)
//   ctl_valid   out  1      running & op in {INC,WAIT}; datapath fields meaningful
//   ready       out  1      ~running
//   done        out  1      1-cycle pulse on any run termination (HALT, error, abort)
//   err_code    out  2      00 ok, 01 stack overflow, 10 stack underflow, 11 WAIT timeout
//   pc_dbg      out  PC_W   current PC
// BEHAVIOUR
//   Reset (async): running=0, pc=0, sp=0, cnt=0, tmo=0, err_code=00, done=0, prog_err=0.
//   Fields: op=instr[2:0], tgt=instr[PC_W+2:3]; ctl_word always full instr.
//   Idle: start&~abort -> running=1, pc<=start_addr, err_code<=00, sp<=0; start&abort -> stays idle.
//   start while running: ignored. prog_we while idle: mem[prog_addr]<=prog_data next edge.
//   Running, one instruction per cycle (abort has priority over all ops: running=0, pc=0, done=1,
//   err_code unchanged):
//     000 INC   pc<=pc+1 (mod 2**PC_W, last address wraps to 0)
//     001 WAIT  continue_i -> pc+1, tmo<=0; else tmo++; if TMO_CYC!=0 and tmo==TMO_CYC-1
//               -> error halt 11. continue_i in the terminal cycle wins (no error).
//     010 HALT  running<=0, pc<=0, done=1, err_code unchanged
//     011 JMP   pc<=tgt
//     100 CALL  sp<STACK_D: stack[sp]<=pc+1 (wrapped), sp++, pc<=tgt; sp==STACK_D -> error halt 01
//     101 RET   sp>0: sp--, pc<=stack[sp-1]; sp==0 -> error halt 10
//     110 LDCNT cnt<=tgt[CNT_W-1:0], pc<=pc+1
//     111 LOOP  cnt!=0: cnt<=cnt-1, pc<=tgt; cnt==0: pc<=pc+1 (body runs N+1 times after LDCNT N)
//   Error halt: running<=0, pc<=0, err_code<=code, done=1; err_code sticky until next accepted start.
//   done, prog_err are registered pulses, high exactly one cycle after the causing edge.
//   tmo cleared whenever op!=WAIT or not running. Stack contents not cleared on start (sp is).
// TESTING
//   prog {INC,INC,HALT} @0, start addr 0 -> pc 0,1,2 then ready=1, done 1 cycle, err=00; ctl_valid 2 cycles
//   LDCNT 3 @0, INC @1, LOOP->1 @2, HALT @3 -> INC executed 4 times, pc trace 0,1,2,1,2,1,2,1,2,3
//   CALL 5 @0, HALT @1, INC @5, RET @6 -> pc 0,5,6,1 halt err=00; 5 nested CALLs (STACK_D=4) -> err=01
//   WAIT @0, TMO_CYC=8, continue never -> halt after 8 cycles err=11; continue on cycle 8 -> pc=1, err=00
//   abort mid-run and async rst_n mid-WAIT -> ready=1, pc=0 (reset: all outputs reset values immediately)
//   prog_we while running -> mem unchanged, prog_err pulse; start while running ignored; PC wrap at 255->0

Source files
------------

// File: rtl/kf_microseq.sv
// Microcode sequencer for the Kalman-filter datapath: PC-addressed control store with
// jump, call/return, counted loop, wait-for-continue with timeout, abort and error reporting.
module kf_microseq #(
  parameter int PC_W    = 8,
  parameter int IW      = 16,
  parameter int STACK_D = 4,
  parameter int CNT_W   = 8,
  parameter int TMO_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            abort,
  input  logic            continue_i,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [IW-1:0]   prog_data,
  output logic            prog_err,
  output logic [IW-1:0]   ctl_word,
  output logic            ctl_valid,
  output logic            ready,
  output logic            done,
  output logic [1:0]      err_code,
  output logic [PC_W-1:0] pc_dbg
);

  if (IW < PC_W + 3) begin : g_bad_iw
    $error("kf_microseq: IW must be at least PC_W+3");
  end
  if (STACK_D < 1) begin : g_bad_stack
    $error("kf_microseq: STACK_D must be at least 1");
  end
  if (CNT_W > PC_W) begin : g_bad_cnt
    $error("kf_microseq: CNT_W must not exceed PC_W");
  end

  localparam int SP_W  = $clog2(STACK_D + 1);
  localparam int SI_W  = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] OP_INC   = 3'b000;
  localparam logic [2:0] OP_WAIT  = 3'b001;
  localparam logic [2:0] OP_HALT  = 3'b010;
  localparam logic [2:0] OP_JMP   = 3'b011;
  localparam logic [2:0] OP_CALL  = 3'b100;
  localparam logic [2:0] OP_RET   = 3'b101;
  localparam logic [2:0] OP_LDCNT = 3'b110;
  localparam logic [2:0] OP_LOOP  = 3'b111;

  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UNF = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  logic [IW-1:0]    mem   [2**PC_W];
  logic [PC_W-1:0]  stack [2**SI_W];

  logic [0:0]       state;
  logic [PC_W-1:0]  pc;
  logic [SP_W-1:0]  sp;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;

  logic             running;
  logic [IW-1:0]    instr;
  logic [2:0]       op;
  logic [PC_W-1:0]  tgt;
  logic [PC_W-1:0]  pc_inc;
  logic             sp_full;
  logic             tmo_expired;
  logic             push_en;

  assign running     = (state == ST_RUN);
  assign instr       = mem[pc];
  assign op          = instr[2:0];
  assign tgt         = instr[PC_W+2:3];
  assign pc_inc      = pc + 1'b1;
  assign sp_full     = (sp == SP_W'(STACK_D));
  assign tmo_expired = (TMO_CYC != 0) && (tmo == TMO_W'(TMO_CYC - 1));
  assign push_en     = running && !abort && (op == OP_CALL) && !sp_full;

  assign ctl_word  = instr;
  assign ctl_valid = running && ((op == OP_INC) || (op == OP_WAIT));
  assign ready     = !running;
  assign pc_dbg    = pc;

  // Store and return stack carry no reset; the stack is only ever read below sp.
  always_ff @(posedge clk) begin
    if (prog_we && !running) mem[prog_addr] <= prog_data;
    if (push_en) stack[SI_W'(sp)] <= pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= '0;
      sp       <= '0;
      cnt      <= '0;
      tmo      <= '0;
      err_code <= 2'b00;
      done     <= 1'b0;
      prog_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      prog_err <= prog_we && running;
      tmo      <= '0;
      if (!running) begin
        if (start && !abort) begin
          state    <= ST_RUN;
          pc       <= start_addr;
          err_code <= 2'b00;
          sp       <= '0;
        end
      end else if (abort) begin
        state <= ST_IDLE;
        pc    <= '0;
        done  <= 1'b1;
      end else begin
        case (op)
          OP_INC: pc <= pc_inc;
          OP_WAIT: begin
            // A continue arriving in the final timeout cycle still releases cleanly.
            if (continue_i) begin
              pc <= pc_inc;
            end else if (tmo_expired) begin
              state    <= ST_IDLE;
              pc       <= '0;
              done     <= 1'b1;
              err_code <= ERR_TMO;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          OP_HALT: begin
            state <= ST_IDLE;
            pc    <= '0;
            done  <= 1'b1;
          end
          OP_JMP: pc <= tgt;
          OP_CALL: begin
            if (sp_full) begin
              state    <= ST_IDLE;
              pc       <= '0;
              done     <= 1'b1;
              err_code <= ERR_OVF;
            end else begin
              sp <= sp + 1'b1;
              pc <= tgt;
            end
          end
          OP_RET: begin
            if (sp == '0) begin
              state    <= ST_IDLE;
              pc       <= '0;
              done     <= 1'b1;
              err_code <= ERR_UNF;
            end else begin
              sp <= sp - 1'b1;
              pc <= stack[SI_W'(sp - 1'b1)];
            end
          end
          OP_LDCNT: begin
            cnt <= tgt[CNT_W-1:0];
            pc  <= pc_inc;
          end
          OP_LOOP: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
              pc  <= tgt;
            end else begin
              pc <= pc_inc;
            end
          end
          default: pc <= pc_inc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kf_microseq.sv
// Self-checking bench for kf_microseq: per-cycle PC traces are queued as expectations before
// each run and popped as the sequencer executes; termination status is checked afterwards.
module tb_kf_microseq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_addr;
  logic        abort;
  logic        continue_i;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        prog_err;
  logic [15:0] ctl_word;
  logic        ctl_valid;
  logic        ready;
  logic        done;
  logic [1:0]  err_code;
  logic [7:0]  pc_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  kf_microseq #(
    .PC_W(8), .IW(16), .STACK_D(4), .CNT_W(8), .TMO_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .abort(abort),
    .continue_i(continue_i), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_err(prog_err), .ctl_word(ctl_word), .ctl_valid(ctl_valid), .ready(ready),
    .done(done), .err_code(err_code), .pc_dbg(pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ins(input logic [2:0] op, input logic [7:0] tgt);
    return {5'b0, tgt, op};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic progWord(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic expectPc(input logic [7:0] p, input int n);
    repeat (n) exp_q.push_back({24'h0, p});
  endtask

  // Runs from addr; the *_at arguments pick the sampled cycle on which a disturbance is driven.
  task automatic applyStimulus(input logic [7:0] addr, input logic [1:0] exp_err,
                               input int exp_valid, input int cont_at, input int abort_at,
                               input int start_at, input int prog_at);
    int cycles;
    int valid_cnt;
    logic [31:0] exp;
    @(negedge clk);
    start = 1'b1; start_addr = addr;
    @(negedge clk);
    start = 1'b0; start_addr = 8'h00;
    cycles = 0;
    valid_cnt = 0;
    while (!ready && cycles < 64) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
      checkOutput("pc", {24'h0, pc_dbg}, exp);
      checkOutput("prog_err", {31'h0, prog_err}, {31'h0, (prog_at >= 0 && cycles == prog_at + 1)});
      valid_cnt += int'(ctl_valid);
      continue_i = (cycles == cont_at);
      abort      = (cycles == abort_at);
      start      = (cycles == start_at);
      prog_we    = (cycles == prog_at);
      prog_addr  = 8'h60;
      prog_data  = ins(3'b010, 8'h00);
      @(negedge clk);
      cycles++;
    end
    continue_i = 1'b0; abort = 1'b0; start = 1'b0; prog_we = 1'b0;
    checkOutput("terminated", {31'h0, ready}, 32'h1);
    checkOutput("trace_left", exp_q.size(), 32'h0);
    checkOutput("done", {31'h0, done}, 32'h1);
    checkOutput("err_code", {30'h0, err_code}, {30'h0, exp_err});
    checkOutput("pc_idle", {24'h0, pc_dbg}, 32'h0);
    checkOutput("valid_cycles", valid_cnt, exp_valid);
    exp_q.delete();
    @(negedge clk);
    checkOutput("done_pulse", {31'h0, done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = 8'h00; abort = 1'b0; continue_i = 1'b0;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 16'h0000;
    #3;
    checkOutput("rst_ready", {31'h0, ready}, 32'h1);
    checkOutput("rst_pc", {24'h0, pc_dbg}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_err", {30'h0, err_code}, 32'h0);
    checkOutput("rst_prog_err", {31'h0, prog_err}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] programming control store");
    progWord(8'h00, ins(3'b000, 8'h00));
    progWord(8'h01, ins(3'b000, 8'h00));
    progWord(8'h02, ins(3'b010, 8'h00));
    progWord(8'h10, ins(3'b110, 8'h03));
    progWord(8'h11, ins(3'b000, 8'h00));
    progWord(8'h12, ins(3'b111, 8'h11));
    progWord(8'h13, ins(3'b010, 8'h00));
    progWord(8'h20, ins(3'b100, 8'h25));
    progWord(8'h21, ins(3'b010, 8'h00));
    progWord(8'h25, ins(3'b000, 8'h00));
    progWord(8'h26, ins(3'b101, 8'h00));
    for (int i = 0; i < 5; i++) progWord(8'h30 + 8'(i), ins(3'b100, 8'h31 + 8'(i)));
    progWord(8'h38, ins(3'b101, 8'h00));
    progWord(8'h40, ins(3'b001, 8'h00));
    progWord(8'h41, ins(3'b010, 8'h00));
    progWord(8'h50, ins(3'b011, 8'h50));
    progWord(8'h60, ins(3'b000, 8'h00));
    progWord(8'h61, ins(3'b010, 8'h00));
    progWord(8'hFE, ins(3'b000, 8'h00));
    progWord(8'hFF, ins(3'b000, 8'h00));
    @(negedge clk);
    checkOutput("idle_prog_err", {31'h0, prog_err}, 32'h0);

    $display("[TB] straight line");
    expectPc(8'h00, 1); expectPc(8'h01, 1); expectPc(8'h02, 1);
    applyStimulus(8'h00, 2'b00, 2, -1, -1, -1, -1);

    $display("[TB] counted loop");
    expectPc(8'h10, 1);
    for (int i = 0; i < 4; i++) begin expectPc(8'h11, 1); expectPc(8'h12, 1); end
    expectPc(8'h13, 1);
    applyStimulus(8'h10, 2'b00, 4, -1, -1, -1, -1);

    $display("[TB] call and return");
    expectPc(8'h20, 1); expectPc(8'h25, 1); expectPc(8'h26, 1); expectPc(8'h21, 1);
    applyStimulus(8'h20, 2'b00, 1, -1, -1, -1, -1);

    $display("[TB] stack overflow and underflow");
    for (int i = 0; i < 5; i++) expectPc(8'h30 + 8'(i), 1);
    applyStimulus(8'h30, 2'b01, 0, -1, -1, -1, -1);
    expectPc(8'h38, 1);
    applyStimulus(8'h38, 2'b10, 0, -1, -1, -1, -1);

    $display("[TB] wait timeout and release");
    expectPc(8'h40, 8);
    applyStimulus(8'h40, 2'b11, 8, -1, -1, -1, -1);
    expectPc(8'h40, 8); expectPc(8'h41, 1);
    applyStimulus(8'h40, 2'b00, 8, 7, -1, -1, -1);
    expectPc(8'h40, 3); expectPc(8'h41, 1);
    applyStimulus(8'h40, 2'b00, 3, 2, -1, -1, -1);

    $display("[TB] abort, start while running, write while running");
    expectPc(8'h50, 6);
    applyStimulus(8'h50, 2'b00, 0, -1, 5, 2, 1);
    expectPc(8'h60, 1); expectPc(8'h61, 1);
    applyStimulus(8'h60, 2'b00, 1, -1, -1, -1, -1);

    $display("[TB] pc wrap");
    expectPc(8'hFE, 1); expectPc(8'hFF, 1); expectPc(8'h00, 1); expectPc(8'h01, 1); expectPc(8'h02, 1);
    applyStimulus(8'hFE, 2'b00, 4, -1, -1, -1, -1);

    $display("[TB] start together with abort while idle");
    @(negedge clk);
    start = 1'b1; abort = 1'b1; start_addr = 8'h50;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("start_abort_ready", {31'h0, ready}, 32'h1);
    checkOutput("start_abort_done", {31'h0, done}, 32'h0);

    $display("[TB] reset while idle clears sticky error");
    expectPc(8'h38, 1);
    applyStimulus(8'h38, 2'b10, 0, -1, -1, -1, -1);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_idle_err", {30'h0, err_code}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] async reset mid-wait");
    @(negedge clk);
    start = 1'b1; start_addr = 8'h40;
    @(negedge clk);
    start = 1'b0;
    checkOutput("wait_running", {31'h0, ready}, 32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_ready", {31'h0, ready}, 32'h1);
    checkOutput("arst_pc", {24'h0, pc_dbg}, 32'h0);
    checkOutput("arst_valid", {31'h0, ctl_valid}, 32'h0);
    checkOutput("arst_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
